// File: rtl/grp_sum_accum_pkg.sv
// Shared state encoding and default widths for the group-sum accumulator.
package grp_sum_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int DEF_DW   = 8;
  localparam int DEF_SW   = 10;
  localparam int DEF_CW   = 8;
  localparam int DEF_GRP  = 4;
  localparam int GRPCNT_W = 16;
endpackage

// File: rtl/grp_sum_accum_if.sv
// Sample input stream and group-result output stream of grp_sum_accum.
interface grp_sum_accum_if
  import grp_sum_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int SW = DEF_SW,
  parameter int CW = DEF_CW
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] out_sum;
  logic [CW-1:0] out_cnt;
  logic          out_ovf;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_cnt, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_cnt, out_ovf
  );
endinterface

// File: rtl/grp_sum_accum_sat_add.sv
// SW-bit unsigned adder with carry-out. With GRP_SUM_SAT_EN defined the result
// saturates to all-ones once any add in the group has overflowed.
module sat_add
  import grp_sum_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int SW = DEF_SW
) (
  input  logic [SW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          sat_in,
  output logic [SW-1:0] sum,
  output logic          ovf
);
  logic [SW:0] full;

  assign full = {1'b0, a} + {{(SW+1-DW){1'b0}}, b};

`ifdef GRP_SUM_SAT_EN
  assign ovf = full[SW] | sat_in;
  assign sum = ovf ? {SW{1'b1}} : full[SW-1:0];
`else
  logic unused_sat;
  assign unused_sat = sat_in ^ full[SW];
  assign ovf        = 1'b0;
  assign sum        = full[SW-1:0];
`endif
endmodule

// File: rtl/grp_sum_accum.sv
// Sums accepted samples in groups of GRP (or fewer on in_last) and hands off each
// group sum/count. Optional overflow saturation: GRP_SUM_SAT_EN.
//
// state | meaning
// IDLE  | no samples collected for the current group
// ACC   | group open, at least one sample accumulated
// HOLD  | group closed, result presented until out_ready
module grp_sum_accum
  import grp_sum_pkg::*;
#(
  parameter int DW  = DEF_DW,
  parameter int GRP = DEF_GRP,
  parameter int SW  = DEF_SW,
  parameter int CW  = DEF_CW,
  parameter int GCW = GRPCNT_W
) (
  input  logic           clk,
  input  logic           rst_n,
  grp_sum_accum_if.slave bus,
  output logic [GCW-1:0] grp_count
);
  state_t        state;
  logic [SW-1:0] acc;
  logic [CW-1:0] cnt;
  logic          in_ready_q;
  logic          out_valid_q;
  logic [SW-1:0] add_a;
  logic [SW-1:0] add_sum;
  logic          add_ovf;
  logic          sat_in;
  logic [CW-1:0] cnt_next;
  logic          closing;

  // First sample of a group starts from zero rather than the stale sum.
  assign add_a    = (state == ACC) ? acc : '0;
  assign cnt_next = (state == ACC) ? cnt + CW'(1) : CW'(1);
  assign closing  = (cnt_next == CW'(GRP)) || bus.in_last;

  sat_add #(.DW(DW), .SW(SW)) u_add (
    .a      (add_a),
    .b      (bus.in_data),
    .sat_in (sat_in),
    .sum    (add_sum),
    .ovf    (add_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= '0;
      cnt         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      grp_count   <= '0;
    end else begin
      case (state)
        IDLE, ACC: begin
          if (bus.in_valid) begin
            acc <= add_sum;
            cnt <= cnt_next;
            if (closing) begin
              state       <= HOLD;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              state <= ACC;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            grp_count   <= grp_count + GCW'(1);
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef GRP_SUM_SAT_EN
  logic ovf_q;

  // Sticky per-group overflow; the first accept of a group overwrites it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (state == HOLD) begin
      if (bus.out_ready) ovf_q <= 1'b0;
    end else if (bus.in_valid) begin
      ovf_q <= add_ovf;
    end
  end

  assign sat_in      = (state == ACC) && ovf_q;
  assign bus.out_ovf = ovf_q & out_valid_q;
`else
  logic unused_ovf;
  assign unused_ovf  = add_ovf;
  assign sat_in      = 1'b0;
  assign bus.out_ovf = 1'b0;
`endif

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = acc;
  assign bus.out_cnt   = cnt;
endmodule

// File: tb/tb_grp_sum_accum.sv
// Bench for grp_sum_accum: a default instance (SW=10) and a narrow one (SW=9,
// 4-bit group counter) fed with identical stimulus and checked against a model.
module tb_grp_sum_accum;
  localparam int G = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       v = 1'b0;
  logic       last = 1'b0;
  logic       rdy = 1'b0;
  logic [7:0] d = 8'd0;
  logic [15:0] gc_a;
  logic [3:0]  gc_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  grp_sum_accum_if #(.DW(8), .SW(10), .CW(8)) ia ();
  grp_sum_accum_if #(.DW(8), .SW(9),  .CW(8)) ib ();

  assign ia.in_valid = v;
  assign ia.in_data = d;
  assign ia.in_last = last;
  assign ia.out_ready = rdy;
  assign ib.in_valid = v;
  assign ib.in_data = d;
  assign ib.in_last = last;
  assign ib.out_ready = rdy;

  grp_sum_accum #(.DW(8), .GRP(G), .SW(10), .CW(8), .GCW(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ia), .grp_count(gc_a));
  grp_sum_accum #(.DW(8), .GRP(G), .SW(9), .CW(8), .GCW(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ib), .grp_count(gc_b));

  // Behavioural reference: exact integer sum per group, reduced to SW bits at close.
  int m_sw[2]   = '{10, 9};
  int m_gmod[2] = '{65536, 16};
  int a_sum[2], a_cnt[2], p_sum[2], p_cnt[2], grp[2];
  bit pend[2], p_ovf[2];

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      a_sum[i] = 0; a_cnt[i] = 0; p_sum[i] = 0; p_cnt[i] = 0;
      grp[i] = 0; pend[i] = 1'b0; p_ovf[i] = 1'b0;
    end
  endfunction

  function automatic void model_step();
    int lim;
    for (int i = 0; i < 2; i++) begin
      if (pend[i]) begin
        if (rdy) begin
          pend[i] = 1'b0;
          grp[i] = (grp[i] + 1) % m_gmod[i];
        end
      end else if (v) begin
        a_sum[i] += int'(d);
        a_cnt[i]++;
        if (a_cnt[i] == G || last) begin
          lim = 1 << m_sw[i];
          if (a_sum[i] >= lim) begin
`ifdef GRP_SUM_SAT_EN
            p_sum[i] = lim - 1; p_ovf[i] = 1'b1;
`else
            p_sum[i] = a_sum[i] % lim; p_ovf[i] = 1'b0;
`endif
          end else begin
            p_sum[i] = a_sum[i]; p_ovf[i] = 1'b0;
          end
          p_cnt[i] = a_cnt[i];
          pend[i] = 1'b1;
          a_sum[i] = 0;
          a_cnt[i] = 0;
        end
      end
    end
  endfunction

  task automatic tick(input bit iv, input logic [7:0] id, input bit il, input bit ir);
    @(negedge clk);
    v = iv; d = id; last = il; rdy = ir;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++; if (ia.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %0d want 0", ia.out_valid); end
    n_cmp++; if (ia.out_sum !== 10'd0) begin n_bad++; $display("FAIL rst_sum: got %0d want 0", ia.out_sum); end
    n_cmp++; if (ia.out_cnt !== 8'd0) begin n_bad++; $display("FAIL rst_cnt: got %0d want 0", ia.out_cnt); end
    n_cmp++; if (ib.out_ovf !== 1'b0) begin n_bad++; $display("FAIL rst_ovf: got %0d want 0", ib.out_ovf); end
    n_cmp++; if (gc_a !== 16'd0) begin n_bad++; $display("FAIL rst_gc: got %0d want 0", gc_a); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (ia.in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %0d want 1", ia.in_ready); end
  endtask

  task automatic test_full_group();
    tick(1, 8'd10, 0, 1);
    tick(1, 8'd20, 0, 1);
    tick(1, 8'd30, 0, 1);
    n_cmp++; if (ia.out_valid !== 1'b0) begin n_bad++; $display("FAIL full_early_valid: got %0d want 0", ia.out_valid); end
    tick(1, 8'd40, 0, 1);
    n_cmp++; if (ia.out_valid !== 1'b1) begin n_bad++; $display("FAIL full_valid: got %0d want 1", ia.out_valid); end
    n_cmp++; if (ia.out_sum !== 10'd100) begin n_bad++; $display("FAIL full_sum: got %0d want 100", ia.out_sum); end
    n_cmp++; if (ia.out_cnt !== 8'd4) begin n_bad++; $display("FAIL full_cnt: got %0d want 4", ia.out_cnt); end
    n_cmp++; if (gc_a !== 16'd0) begin n_bad++; $display("FAIL full_gc0: got %0d want 0", gc_a); end
    tick(0, 8'd0, 0, 1);
    n_cmp++; if (ia.out_valid !== 1'b0) begin n_bad++; $display("FAIL full_one_cycle: got %0d want 0", ia.out_valid); end
    n_cmp++; if (gc_a !== 16'd1) begin n_bad++; $display("FAIL full_gc1: got %0d want 1", gc_a); end
  endtask

  task automatic test_last();
    tick(1, 8'd5, 0, 1);
    tick(1, 8'd7, 1, 1);
    n_cmp++; if (ia.out_sum !== 10'd12) begin n_bad++; $display("FAIL last_sum: got %0d want 12", ia.out_sum); end
    n_cmp++; if (ia.out_cnt !== 8'd2) begin n_bad++; $display("FAIL last_cnt: got %0d want 2", ia.out_cnt); end
    // Sample offered during the emit cycle must be ignored (bubble).
    tick(1, 8'd1, 1, 1);
    for (int i = 0; i < 4; i++) tick(1, 8'd1, 0, 0);
    n_cmp++; if (ia.out_sum !== 10'd4) begin n_bad++; $display("FAIL last_next_sum: got %0d want 4", ia.out_sum); end
    n_cmp++; if (ia.out_cnt !== 8'd4) begin n_bad++; $display("FAIL last_next_cnt: got %0d want 4", ia.out_cnt); end
    tick(0, 8'd0, 0, 1);
    n_cmp++; if (gc_a !== 16'd3) begin n_bad++; $display("FAIL last_gc: got %0d want 3", gc_a); end
  endtask

  task automatic test_backpressure();
    for (int i = 1; i <= 4; i++) tick(1, 8'(i), 0, 0);
    for (int k = 0; k < 5; k++) begin
      tick(1, 8'd99, 0, 0);
      n_cmp++; if (ia.out_sum !== 10'd10) begin n_bad++; $display("FAIL hold_sum[%0d]: got %0d want 10", k, ia.out_sum); end
      n_cmp++; if (ia.out_valid !== 1'b1) begin n_bad++; $display("FAIL hold_valid[%0d]: got %0d want 1", k, ia.out_valid); end
      n_cmp++; if (ia.in_ready !== 1'b0) begin n_bad++; $display("FAIL hold_ready[%0d]: got %0d want 0", k, ia.in_ready); end
    end
    tick(0, 8'd0, 0, 1);
    n_cmp++; if (ia.in_ready !== 1'b1) begin n_bad++; $display("FAIL hold_release_ready: got %0d want 1", ia.in_ready); end
    n_cmp++; if (gc_a !== 16'd4) begin n_bad++; $display("FAIL hold_gc: got %0d want 4", gc_a); end
  endtask

  task automatic test_overflow();
    logic [8:0] want_b;
    logic       want_ovf;
`ifdef GRP_SUM_SAT_EN
    want_b = 9'd511; want_ovf = 1'b1;
`else
    want_b = 9'd508; want_ovf = 1'b0;
`endif
    for (int i = 0; i < 4; i++) tick(1, 8'd255, 0, 0);
    n_cmp++; if (ia.out_sum !== 10'd1020) begin n_bad++; $display("FAIL ovf_a_sum: got %0d want 1020", ia.out_sum); end
    n_cmp++; if (ia.out_ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_a_flag: got %0d want 0", ia.out_ovf); end
    n_cmp++; if (ib.out_sum !== want_b) begin n_bad++; $display("FAIL ovf_b_sum: got %0d want %0d", ib.out_sum, want_b); end
    n_cmp++; if (ib.out_ovf !== want_ovf) begin n_bad++; $display("FAIL ovf_b_flag: got %0d want %0d", ib.out_ovf, want_ovf); end
    tick(0, 8'd0, 0, 1);
    n_cmp++; if (ib.out_ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_b_clear: got %0d want 0", ib.out_ovf); end
  endtask

  task automatic test_reset_mid();
    tick(1, 8'd1, 0, 0);
    tick(1, 8'd2, 0, 0);
    @(negedge clk);
    v = 1'b0; rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    n_cmp++; if (ia.out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_valid: got %0d want 0", ia.out_valid); end
    n_cmp++; if (ia.out_sum !== 10'd0) begin n_bad++; $display("FAIL mid_rst_sum: got %0d want 0", ia.out_sum); end
    n_cmp++; if (ia.out_cnt !== 8'd0) begin n_bad++; $display("FAIL mid_rst_cnt: got %0d want 0", ia.out_cnt); end
    n_cmp++; if (gc_a !== 16'd0) begin n_bad++; $display("FAIL mid_rst_gc: got %0d want 0", gc_a); end
    n_cmp++; if (ia.in_ready !== 1'b1) begin n_bad++; $display("FAIL mid_rst_ready: got %0d want 1", ia.in_ready); end
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) tick(1, 8'(i), 0, 1);
    n_cmp++; if (ia.out_sum !== 10'd10) begin n_bad++; $display("FAIL mid_next_sum: got %0d want 10", ia.out_sum); end
    tick(0, 8'd0, 0, 1);
    n_cmp++; if (gc_a !== 16'd1) begin n_bad++; $display("FAIL mid_next_gc: got %0d want 1", gc_a); end
  endtask

  task automatic test_count_wrap();
    for (int i = 0; i < 15; i++) begin
      tick(1, 8'(i), 1, 1);
      n_cmp++; if (ia.out_cnt !== 8'd1) begin n_bad++; $display("FAIL wrap_single_cnt[%0d]: got %0d want 1", i, ia.out_cnt); end
      tick(0, 8'd0, 0, 1);
    end
    n_cmp++; if (gc_a !== 16'd16) begin n_bad++; $display("FAIL wrap_gc_a: got %0d want 16", gc_a); end
    n_cmp++; if (gc_b !== 4'd0) begin n_bad++; $display("FAIL wrap_gc_b: got %0d want 0", gc_b); end
  endtask

  task automatic test_random();
    bit iv, il, ir;
    logic [7:0] id;
    for (int c = 0; c < 600; c++) begin
      iv = ($urandom_range(0, 3) != 0);
      il = ($urandom_range(0, 5) == 0);
      ir = ($urandom_range(0, 2) != 0);
      id = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
      tick(iv, id, il, ir);
      n_cmp++; if (ia.out_valid !== pend[0]) begin n_bad++; $display("FAIL rnd_a_valid@%0d: got %0d want %0d", c, ia.out_valid, pend[0]); end
      n_cmp++; if (ia.in_ready !== !pend[0]) begin n_bad++; $display("FAIL rnd_a_ready@%0d: got %0d want %0d", c, ia.in_ready, !pend[0]); end
      n_cmp++; if (gc_a !== 16'(grp[0])) begin n_bad++; $display("FAIL rnd_a_gc@%0d: got %0d want %0d", c, gc_a, grp[0]); end
      n_cmp++; if (gc_b !== 4'(grp[1])) begin n_bad++; $display("FAIL rnd_b_gc@%0d: got %0d want %0d", c, gc_b, grp[1]); end
      n_cmp++; if (ib.out_valid !== pend[1]) begin n_bad++; $display("FAIL rnd_b_valid@%0d: got %0d want %0d", c, ib.out_valid, pend[1]); end
      if (pend[0]) begin
        n_cmp++; if (ia.out_sum !== 10'(p_sum[0])) begin n_bad++; $display("FAIL rnd_a_sum@%0d: got %0d want %0d", c, ia.out_sum, p_sum[0]); end
        n_cmp++; if (ia.out_cnt !== 8'(p_cnt[0])) begin n_bad++; $display("FAIL rnd_a_cnt@%0d: got %0d want %0d", c, ia.out_cnt, p_cnt[0]); end
        n_cmp++; if (ia.out_ovf !== p_ovf[0]) begin n_bad++; $display("FAIL rnd_a_ovf@%0d: got %0d want %0d", c, ia.out_ovf, p_ovf[0]); end
      end
      if (pend[1]) begin
        n_cmp++; if (ib.out_sum !== 9'(p_sum[1])) begin n_bad++; $display("FAIL rnd_b_sum@%0d: got %0d want %0d", c, ib.out_sum, p_sum[1]); end
        n_cmp++; if (ib.out_cnt !== 8'(p_cnt[1])) begin n_bad++; $display("FAIL rnd_b_cnt@%0d: got %0d want %0d", c, ib.out_cnt, p_cnt[1]); end
        n_cmp++; if (ib.out_ovf !== p_ovf[1]) begin n_bad++; $display("FAIL rnd_b_ovf@%0d: got %0d want %0d", c, ib.out_ovf, p_ovf[1]); end
      end else begin
        n_cmp++; if (ib.out_ovf !== 1'b0) begin n_bad++; $display("FAIL rnd_b_ovf_idle@%0d: got %0d want 0", c, ib.out_ovf); end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_full_group();
    test_last();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    test_count_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
